// File: rtl/mbus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbus_arb_pkg
// Description : Shared types and constants for the two-requester memory-bus
//               arbiter: requester id, channel FSM states, write response code.
// Revision    : 1.0 - initial release
// ============================================================================
package mbus_arb_pkg;

    // Requester identifier: M0 = vector memory queue, M1 = secondary port
    typedef logic [0:0] master_id_t;
    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    // Channel FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD
    } arb_state_e;

    // Write response code for a successful transfer
    localparam logic [1:0] OKAY = 2'b00;

    // The requester that is not 'id' (round-robin hand-off)
    function automatic master_id_t other_id(input master_id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbus_ord_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mbus_ord_fifo
// Description : Small order FIFO recording which requester owns each issued
//               bus transaction, so in-order responses can be steered back.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n     - clock, synchronous active-low reset
//               push, push_id  - record an issued transaction's owner
//               pop            - retire the oldest entry
//               full, empty    - occupancy flags (from the current count)
//               head           - owner of the oldest outstanding transaction
// ============================================================================
module mbus_ord_fifo
    import mbus_arb_pkg::*;
#(
    parameter int OUTST_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t head
);

    localparam int                  C_DEPTH     = 2 ** OUTST_BITS;
    localparam logic [OUTST_BITS:0] C_DEPTH_CNT = {1'b1, {OUTST_BITS{1'b0}}};

    master_id_t              r_mem [C_DEPTH];
    logic [OUTST_BITS-1:0]   r_wr_ptr;
    logic [OUTST_BITS-1:0]   r_rd_ptr;
    logic [OUTST_BITS:0]     r_count;
    logic                    w_push_en;
    logic                    w_pop_en;

    assign full  = (r_count == C_DEPTH_CNT);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // A push is refused while full even if a pop retires an entry this cycle
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_en && !w_pop_en) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_en && w_pop_en) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mbus_arbiter
// Description : Shares one single-beat AXI-style memory bus between M0 (vector
//               memory queue) and M1. Read and write channels are arbitrated
//               independently with round-robin grant; a stalled grant is held
//               until the bus accepts it. Responses return in issue order and
//               are steered to their owner via per-channel order FIFOs.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               m{0,1}_ar/r         - requester read address / data channels
//               m{0,1}_aw/w/b       - requester write address/data/response
//               mbus_ar/r/aw/w/b    - shared downstream bus channels
// ============================================================================
module mbus_arbiter
    import mbus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int OUTST_BITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // M0 requester
    input  logic [ADDR_WIDTH-1:0]   m0_ar_addr,
    input  logic                    m0_ar_valid,
    output logic                    m0_ar_ready,
    output logic [DATA_WIDTH-1:0]   m0_r_data,
    output logic                    m0_r_valid,
    input  logic                    m0_r_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_aw_addr,
    input  logic                    m0_aw_valid,
    output logic                    m0_aw_ready,
    input  logic [DATA_WIDTH-1:0]   m0_w_data,
    input  logic [DATA_WIDTH/8-1:0] m0_w_strb,
    output logic [1:0]              m0_b_resp,
    output logic                    m0_b_valid,
    input  logic                    m0_b_ready,
    // M1 requester
    input  logic [ADDR_WIDTH-1:0]   m1_ar_addr,
    input  logic                    m1_ar_valid,
    output logic                    m1_ar_ready,
    output logic [DATA_WIDTH-1:0]   m1_r_data,
    output logic                    m1_r_valid,
    input  logic                    m1_r_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_aw_addr,
    input  logic                    m1_aw_valid,
    output logic                    m1_aw_ready,
    input  logic [DATA_WIDTH-1:0]   m1_w_data,
    input  logic [DATA_WIDTH/8-1:0] m1_w_strb,
    output logic [1:0]              m1_b_resp,
    output logic                    m1_b_valid,
    input  logic                    m1_b_ready,
    // Shared bus
    output logic [ADDR_WIDTH-1:0]   mbus_ar_addr,
    output logic                    mbus_ar_valid,
    input  logic                    mbus_ar_ready,
    input  logic [DATA_WIDTH-1:0]   mbus_r_data,
    input  logic                    mbus_r_valid,
    output logic                    mbus_r_ready,
    output logic [ADDR_WIDTH-1:0]   mbus_aw_addr,
    output logic                    mbus_aw_valid,
    input  logic                    mbus_aw_ready,
    output logic [DATA_WIDTH-1:0]   mbus_w_data,
    output logic [DATA_WIDTH/8-1:0] mbus_w_strb,
    output logic                    mbus_w_valid,
    input  logic [1:0]              mbus_b_resp,
    input  logic                    mbus_b_valid,
    output logic                    mbus_b_ready
);

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    logic [0:0] r_rd_state;
    master_id_t r_rd_gnt;
    master_id_t r_rd_rr;
    master_id_t w_rd_sel;
    logic       w_rd_req;
    logic       w_rd_hs;
    logic       w_rd_full;
    logic       w_rd_empty;
    master_id_t w_rd_head;

    // HOLD pins the latched requester; otherwise a lone requester wins and a
    // contested cycle goes to the round-robin pointer.
    always_comb begin
        w_rd_sel = M0;
        if (r_rd_state == ST_HOLD) begin
            w_rd_sel = r_rd_gnt;
        end else if (m0_ar_valid && m1_ar_valid) begin
            w_rd_sel = r_rd_rr;
        end else if (m1_ar_valid) begin
            w_rd_sel = M1;
        end
    end

    assign w_rd_req      = !w_rd_full && ((w_rd_sel == M1) ? m1_ar_valid : m0_ar_valid);
    assign w_rd_hs       = w_rd_req && mbus_ar_ready;
    assign mbus_ar_valid = w_rd_req;
    assign mbus_ar_addr  = !w_rd_req ? '0 : ((w_rd_sel == M1) ? m1_ar_addr : m0_ar_addr);
    assign m0_ar_ready   = w_rd_hs && (w_rd_sel == M0);
    assign m1_ar_ready   = w_rd_hs && (w_rd_sel == M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= ST_IDLE;
            r_rd_gnt   <= M0;
            r_rd_rr    <= M0;
        end else begin
            if (w_rd_hs) begin
                r_rd_rr <= other_id(w_rd_sel);
            end
            if (r_rd_state == ST_IDLE) begin
                if (w_rd_req && !mbus_ar_ready) begin
                    r_rd_state <= ST_HOLD;
                    r_rd_gnt   <= w_rd_sel;
                end
            end else if (w_rd_hs) begin
                r_rd_state <= ST_IDLE;
            end
        end
    end

    mbus_ord_fifo #(
        .OUTST_BITS (OUTST_BITS)
    ) u_rd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_rd_hs),
        .push_id (w_rd_sel),
        .pop     (mbus_r_valid && mbus_r_ready),
        .full    (w_rd_full),
        .empty   (w_rd_empty),
        .head    (w_rd_head)
    );

    // Read data goes to both requesters; only the valid is steered
    assign mbus_r_ready = !w_rd_empty && ((w_rd_head == M1) ? m1_r_ready : m0_r_ready);
    assign m0_r_valid   = mbus_r_valid && !w_rd_empty && (w_rd_head == M0);
    assign m1_r_valid   = mbus_r_valid && !w_rd_empty && (w_rd_head == M1);
    assign m0_r_data    = mbus_r_data;
    assign m1_r_data    = mbus_r_data;

    // ------------------------------------------------------------------------
    // Write channel (aw and w travel together as one beat)
    // ------------------------------------------------------------------------
    logic [0:0] r_wr_state;
    master_id_t r_wr_gnt;
    master_id_t r_wr_rr;
    master_id_t w_wr_sel;
    logic       w_wr_req;
    logic       w_wr_hs;
    logic       w_wr_full;
    logic       w_wr_empty;
    master_id_t w_wr_head;

    always_comb begin
        w_wr_sel = M0;
        if (r_wr_state == ST_HOLD) begin
            w_wr_sel = r_wr_gnt;
        end else if (m0_aw_valid && m1_aw_valid) begin
            w_wr_sel = r_wr_rr;
        end else if (m1_aw_valid) begin
            w_wr_sel = M1;
        end
    end

    assign w_wr_req      = !w_wr_full && ((w_wr_sel == M1) ? m1_aw_valid : m0_aw_valid);
    assign w_wr_hs       = w_wr_req && mbus_aw_ready;
    assign mbus_aw_valid = w_wr_req;
    assign mbus_w_valid  = w_wr_req;
    assign mbus_aw_addr  = !w_wr_req ? '0 : ((w_wr_sel == M1) ? m1_aw_addr : m0_aw_addr);
    assign mbus_w_data   = !w_wr_req ? '0 : ((w_wr_sel == M1) ? m1_w_data : m0_w_data);
    assign mbus_w_strb   = !w_wr_req ? '0 : ((w_wr_sel == M1) ? m1_w_strb : m0_w_strb);
    assign m0_aw_ready   = w_wr_hs && (w_wr_sel == M0);
    assign m1_aw_ready   = w_wr_hs && (w_wr_sel == M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= ST_IDLE;
            r_wr_gnt   <= M0;
            r_wr_rr    <= M0;
        end else begin
            if (w_wr_hs) begin
                r_wr_rr <= other_id(w_wr_sel);
            end
            if (r_wr_state == ST_IDLE) begin
                if (w_wr_req && !mbus_aw_ready) begin
                    r_wr_state <= ST_HOLD;
                    r_wr_gnt   <= w_wr_sel;
                end
            end else if (w_wr_hs) begin
                r_wr_state <= ST_IDLE;
            end
        end
    end

    mbus_ord_fifo #(
        .OUTST_BITS (OUTST_BITS)
    ) u_wr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_wr_hs),
        .push_id (w_wr_sel),
        .pop     (mbus_b_valid && mbus_b_ready),
        .full    (w_wr_full),
        .empty   (w_wr_empty),
        .head    (w_wr_head)
    );

    assign mbus_b_ready = !w_wr_empty && ((w_wr_head == M1) ? m1_b_ready : m0_b_ready);
    assign m0_b_valid   = mbus_b_valid && !w_wr_empty && (w_wr_head == M0);
    assign m1_b_valid   = mbus_b_valid && !w_wr_empty && (w_wr_head == M1);
    assign m0_b_resp    = mbus_b_resp;
    assign m1_b_resp    = mbus_b_resp;

endmodule
`default_nettype wire

// File: doc/mbus_arbiter.md
# mbus_arbiter

Two-requester arbiter sharing one single-beat AXI-style memory bus (ar/r, aw/w/b; no IDs, in-order responses) between the vector memory queue (M0) and a second requester (M1, e.g. scalar/prefetch port). Placed between the requesters and the top-level `mbus_*` ports of the vector unit. Round-robin grant per channel, address held stable while stalled, responses steered back in issue order via small order FIFOs.

## Interface
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 64, bus data width; strobe width `DATA_WIDTH/8`
- `OUTST_BITS`, 2, log2 of max outstanding transactions per channel (depth 4)

- `clk` in 1, single clock
- `rst_n` in 1, synchronous active-low reset
- `m{0,1}_ar_addr` in ADDR_WIDTH; `m{0,1}_ar_valid` in 1; `m{0,1}_ar_ready` out 1
- `m{0,1}_r_data` out DATA_WIDTH; `m{0,1}_r_valid` out 1; `m{0,1}_r_ready` in 1
- `m{0,1}_aw_addr` in ADDR_WIDTH; `m{0,1}_aw_valid` in 1; `m{0,1}_aw_ready` out 1
- `m{0,1}_w_data` in DATA_WIDTH; `m{0,1}_w_strb` in DATA_WIDTH/8 (qualified by the same requester's aw_valid)
- `m{0,1}_b_resp` out 2; `m{0,1}_b_valid` out 1; `m{0,1}_b_ready` in 1
- `mbus_ar_addr` out ADDR_WIDTH; `mbus_ar_valid` out 1; `mbus_ar_ready` in 1
- `mbus_r_data` in DATA_WIDTH; `mbus_r_valid` in 1; `mbus_r_ready` out 1
- `mbus_aw_addr` out ADDR_WIDTH; `mbus_aw_valid` out 1; `mbus_aw_ready` in 1
- `mbus_w_data` out DATA_WIDTH; `mbus_w_strb` out DATA_WIDTH/8; `mbus_w_valid` out 1 (equals `mbus_aw_valid`)
- `mbus_b_resp` in 2; `mbus_b_valid` in 1; `mbus_b_ready` out 1

## Operation
- Read and write channels arbitrated independently; identical logic per channel.
- Per-channel FSM: IDLE, HOLD.
  - IDLE: if order FIFO full → no grant, `mbus_*_valid`=0. Else pick requester: only one valid → it; both valid → the one `rr_ptr` points to. Forward addr (and w data/strb) combinationally.
  - Granted valid && !bus ready → latch grant, go HOLD.
  - HOLD: grant fixed to latched requester; requester must keep valid/addr/data stable; on bus ready → handshake, go IDLE.
  - On every handshake: push granted id into order FIFO; `rr_ptr` ← other requester.
- Requester ready = bus ready && granted && FIFO not full; ungranted ready = 0.
- Response steering: FIFO head id selects target. `mbus_r_ready` = head requester's `r_ready` when FIFO non-empty, else 0. Target `r_valid` = `mbus_r_valid` && non-empty; other requester's `r_valid` = 0. Pop on `mbus_r_valid && mbus_r_ready`. Same for b.
- r/b data and resp forwarded to both requesters unmodified; only valids steered.
- FIFO full check uses current count; push blocked when full even if pop occurs same cycle.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Response with empty FIFO: not accepted (ready 0), no pop, no underflow.

## Timing
- Reset values: all `*_valid`, `*_ready` outputs 0; data/addr outputs 0 (mux of zeroed grant); FSMs IDLE; `rr_ptr`=M0; FIFOs empty.
- Request path zero-latency combinational: requester valid in cycle N → `mbus_ar_valid` cycle N.
- Response path zero-latency combinational through FIFO head.
- Grant latch, `rr_ptr`, FIFO pointers update on `clk` rising edge.
- Reset mid-operation: all state cleared next edge; in-flight responses arriving after reset are not accepted; callers quiesce bus before reset.

## Structure
- Package `mbus_arb_pkg`: `master_id_t` (1 bit, M0=0, M1=1), `arb_state_e` {IDLE, HOLD}, bresp constant OKAY=2'b00.
- Sub-module `mbus_ord_fifo` (depth 2**OUTST_BITS, width 1, push/pop/full/empty/head, sync active-low reset), instantiated once for reads, once for writes.
- Top `mbus_arbiter`: two channel FSMs, rr pointers, muxing.

## Test plan
- M0 ar 0x1000 alone, `mbus_ar_ready`=1 → same-cycle `mbus_ar_addr`=0x1000, `m0_ar_ready`=1; r data 0xAA..AA returns → only `m0_r_valid`=1.
- M0 0x1000 and M1 0x2000 both valid every cycle, ready=1 → issue order 0x1000, 0x2000, 0x1000, 0x2000; responses D0..D3 delivered M0,M1,M0,M1.
- M1 granted, `mbus_ar_ready`=0 for 3 cycles while M0 asserts → `mbus_ar_addr` stays M1 addr (HOLD), M1 issued on cycle 4, M0 next.
- 4 reads issued with no r returned → FIFO full, 5th request sees `mbus_ar_valid`=0 and ready 0; one r pop → next cycle issue resumes.
- M0 write 0x3000/data 0x1122334455667788/strb 0xFF → `mbus_w_valid`=`mbus_aw_valid`, data/strb forwarded; b resp 2'b00 → `m0_b_valid`=1 only; `mbus_r_valid` with empty FIFO → `mbus_r_ready`=0.
- Assert `rst_n`=0 with 2 reads outstanding and M1 in HOLD → next cycle all valids/readys 0, `rr_ptr`=M0, FIFOs empty.
